// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared types for the multiply/divide unit.
//   op_e    : MDU op codes, values taken from defines.vh
//   state_e : controller states
//   mag32() : magnitude of a 32-bit operand when treated as signed
`include "defines.vh"

package mdu_pkg;

   localparam int OP_W  = `MDU_CWIDTH;
   localparam int STEPS = 32;

   typedef enum logic [OP_W-1:0] {
      OP_MULT  = `MDU_OP_MULT,
      OP_MULTU = `MDU_OP_MULTU,
      OP_DIV   = `MDU_OP_DIV,
      OP_DIVU  = `MDU_OP_DIVU,
      OP_MTHI  = `MDU_OP_MTHI,
      OP_MTLO  = `MDU_OP_MTLO
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_e;

   // Two's-complement magnitude; 32'h80000000 maps to itself, which is the
   // correct unsigned magnitude for the iterative datapath.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic use_sign);
      return (use_sign && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/defines.vh
// MDU op-code width and encodings, kept beside the ALU op codes so decode
// logic and the multiply/divide unit agree on one table.
`ifndef MDU_DEFINES_VH
`define MDU_DEFINES_VH

`define MDU_CWIDTH   3
`define MDU_OP_MULT  3'd0
`define MDU_OP_MULTU 3'd1
`define MDU_OP_DIV   3'd2
`define MDU_OP_DIVU  3'd3
`define MDU_OP_MTHI  3'd4
`define MDU_OP_MTLO  3'd5

`endif

// File: rtl/mdu_iter.sv
// mdu_iter -- one-bit-per-cycle unsigned multiply / divide datapath.
//   clk, rst : clock, synchronous active-high reset (clears all state)
//   load     : capture operands a/b for a new operation (mode from is_div)
//   step     : advance one iteration (mode from is_div)
//   is_div   : 1 = restoring divide, 0 = shift-add multiply
//   a, b     : multiplicand/multiplier or dividend/divisor (unsigned)
//   prod     : 64-bit product accumulator
//   quo, rem : quotient and remainder
module mdu_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic        is_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] prod,
   output logic [31:0] quo,
   output logic [31:0] rem
);

   logic [63:0] acc;      // {partial product, remaining multiplier bits}
   logic [31:0] mcand;    // multiplicand or divisor
   logic [31:0] qsh;      // dividend bits shifting out, quotient bits in
   logic [31:0] prem;     // settled remainder (always < divisor)

   logic [32:0] add_sum;
   logic [32:0] part_rem; // 33-bit partial remainder for this step
   logic        fits;
   logic [31:0] diff;

   always_comb begin
      add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
      part_rem = {prem, qsh[31]};
      fits     = (part_rem >= {1'b0, mcand});
      // When the divisor fits, the true difference is below 2^32, so the
      // low 32 bits of the subtraction are exact.
      diff     = part_rem[31:0] - mcand;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         mcand <= '0;
         qsh   <= '0;
         prem  <= '0;
      end else if (load) begin
         mcand <= is_div ? b : a;
         acc   <= is_div ? 64'd0 : {32'd0, b};
         qsh   <= is_div ? a : 32'd0;
         prem  <= '0;
      end else if (step) begin
         if (is_div) begin
            prem <= fits ? diff : part_rem[31:0];
            qsh  <= {qsh[30:0], fits};
         end else begin
            acc  <= {add_sum, acc[31:1]};
         end
      end
   end

   assign prod = acc;
   assign quo  = qsh;
   assign rem  = prem;

endmodule

// File: rtl/mdu.sv
// mdu -- MIPS-style HI/LO multiply/divide unit.
//   iClk, iRst : clock, synchronous active-high reset
//   iStart     : request strobe, sampled with iOp/iA/iB while idle
//   iOp        : MULT, MULTU, DIV, DIVU, MTHI, MTLO
//   iA, iB     : rs / rt operands
//   oBusy      : iteration in progress
//   oDone      : one-cycle pulse after HI/LO are written by mult/div
//   oHi, oLo   : architectural HI/LO registers
// Compile-time option: MDU_FAST_MUL_EN -- single-cycle multiply instead of
// the 32-step iterative one. Divide is iterative in both builds.
module mdu
   import mdu_pkg::*;
(
   input  logic            iClk,
   input  logic            iRst,
   input  logic            iStart,
   input  logic [OP_W-1:0] iOp,
   input  logic [31:0]     iA,
   input  logic [31:0]     iB,
   output logic            oBusy,
   output logic            oDone,
   output logic [31:0]     oHi,
   output logic [31:0]     oLo
);

   state_e      state;
   op_e         op_q;
   logic [4:0]  step_cnt;
   logic        neg_lo;   // negate quotient (div)
   logic        neg_hi;   // negate product (mul) or remainder (div)

   logic        is_signed, is_mul, is_div_op, sign_a, sign_b, b_zero, iter_go;
   logic [31:0] mag_a, mag_b;
   logic        iter_load, iter_step, iter_is_div;
   logic [63:0] prod, prod_fix;
   logic [31:0] quo, rem, res_hi, res_lo;

   // NOTE: every variable written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      is_signed = (iOp == OP_MULT) || (iOp == OP_DIV);
      is_mul    = (iOp == OP_MULT) || (iOp == OP_MULTU);
      is_div_op = (iOp == OP_DIV)  || (iOp == OP_DIVU);
      sign_a    = is_signed & iA[31];
      sign_b    = is_signed & iB[31];
      b_zero    = (iB == 32'd0);
      mag_a     = mag32(iA, is_signed);
      mag_b     = mag32(iB, is_signed);
`ifdef MDU_FAST_MUL_EN
      iter_go   = is_div_op;
`else
      iter_go   = is_div_op | is_mul;
`endif
   end

   assign iter_load   = (state == S_IDLE) && iStart && iter_go;
   assign iter_step   = (state == S_MUL) || (state == S_DIV);
   assign iter_is_div = (state == S_IDLE) ? is_div_op : (state == S_DIV);

   mdu_iter u_iter (
      .clk    (iClk),
      .rst    (iRst),
      .load   (iter_load),
      .step   (iter_step),
      .is_div (iter_is_div),
      .a      (mag_a),
      .b      (mag_b),
      .prod   (prod),
      .quo    (quo),
      .rem    (rem)
   );

   // Sign correction applied in FIX; the iterative datapath is unsigned.
   always_comb begin
      prod_fix = neg_hi ? (64'd0 - prod) : prod;
      res_hi   = prod_fix[63:32];
      res_lo   = prod_fix[31:0];
      if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
         res_lo = neg_lo ? (32'd0 - quo) : quo;
         res_hi = neg_hi ? (32'd0 - rem) : rem;
      end
   end

`ifdef MDU_FAST_MUL_EN
   logic [63:0] fast_prod;
   // Low 64 bits of the product of sign-extended operands are the signed
   // product; zero extension gives the unsigned one.
   always_comb begin
      fast_prod = {{32{sign_a}}, iA} * {{32{sign_b}}, iB};
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state    <= S_IDLE;
         op_q     <= OP_MULT;
         step_cnt <= '0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         oBusy    <= 1'b0;
         oDone    <= 1'b0;
         oHi      <= '0;
         oLo      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (iStart) begin
                  case (iOp)
                     OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                        oHi   <= fast_prod[63:32];
                        oLo   <= fast_prod[31:0];
                        oDone <= 1'b1;
                        state <= S_DONE;
`else
                        op_q     <= op_e'(iOp);
                        neg_hi   <= sign_a ^ sign_b;
                        neg_lo   <= sign_a ^ sign_b;
                        step_cnt <= '0;
                        oBusy    <= 1'b1;
                        state    <= S_MUL;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        op_q     <= op_e'(iOp);
                        // A zero divisor yields an all-ones quotient that
                        // must not be negated.
                        neg_lo   <= (sign_a ^ sign_b) & ~b_zero;
                        neg_hi   <= sign_a;
                        step_cnt <= '0;
                        oBusy    <= 1'b1;
                        state    <= S_DIV;
                     end
                     OP_MTHI: oHi <= iA;
                     OP_MTLO: oLo <= iA;
                     default: ;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               step_cnt <= step_cnt + 5'd1;
               if (step_cnt == 5'(STEPS - 1)) state <= S_FIX;
            end
            S_FIX: begin
               oHi   <= res_hi;
               oLo   <= res_lo;
               oBusy <= 1'b0;
               oDone <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               oDone <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- directed self-checking bench for mdu.
module tb_mdu;
   import mdu_pkg::*;

   logic            iClk = 1'b0;
   logic            iRst;
   logic            iStart;
   logic [OP_W-1:0] iOp;
   logic [31:0]     iA;
   logic [31:0]     iB;
   logic            oBusy;
   logic            oDone;
   logic [31:0]     oHi;
   logic [31:0]     oLo;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] cur_hi = '0;
   logic [31:0] cur_lo = '0;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_BUSY = 0;
`else
   localparam int MUL_BUSY = 33;
`endif
   localparam int DIV_BUSY = 33;

   mdu dut (
      .iClk   (iClk),
      .iRst   (iRst),
      .iStart (iStart),
      .iOp    (iOp),
      .iA     (iA),
      .iB     (iB),
      .oBusy  (oBusy),
      .oDone  (oDone),
      .oHi    (oHi),
      .oLo    (oLo)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge iClk);
      #1;
   endtask

   task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
      iStart = 1'b1;
      iOp    = op;
      iA     = a;
      iB     = b;
      cyc();
      iStart = 1'b0;
   endtask

   // Issue one mult/div, count busy cycles, check hold of HI/LO mid-run,
   // optionally inject an ignored MTLO strobe, then check results and pulse.
   task automatic run_op(input string tag, input logic [OP_W-1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_busy, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int inject);
      int busy_cnt = 0;
      issue(op, a, b);
      while (oBusy === 1'b1 && busy_cnt < 100) begin
         busy_cnt++;
         if (busy_cnt == 16) begin
            check({tag, "_hold_hi"}, oHi, cur_hi);
            check({tag, "_hold_lo"}, oLo, cur_lo);
         end
         if (busy_cnt == inject) begin
            iStart = 1'b1;
            iOp    = OP_MTLO;
            iA     = 32'hDEAD_0000;
         end
         cyc();
         iStart = 1'b0;
      end
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      check({tag, "_done"}, 32'(oDone), 32'd1);
      check({tag, "_hi"}, oHi, exp_hi);
      check({tag, "_lo"}, oLo, exp_lo);
      cur_hi = exp_hi;
      cur_lo = exp_lo;
      cyc();
      check({tag, "_done_clear"}, 32'(oDone), 32'd0);
   endtask

   initial begin
      int done_seen;
      iRst   = 1'b1;
      iStart = 1'b0;
      iOp    = '0;
      iA     = '0;
      iB     = '0;
      repeat (2) cyc();
      check("rst_busy", 32'(oBusy), 32'd0);
      check("rst_done", 32'(oDone), 32'd0);
      check("rst_hi", oHi, 32'd0);
      check("rst_lo", oLo, 32'd0);
      iRst = 1'b0;
      cyc();

      // Moves to HI/LO take effect at the issue edge.
      issue(OP_MTHI, 32'h0000_CAFE, 32'd0);
      check("mthi_hi", oHi, 32'h0000_CAFE);
      check("mthi_lo", oLo, 32'd0);
      check("mthi_busy", 32'(oBusy), 32'd0);
      check("mthi_done", 32'(oDone), 32'd0);
      cur_hi = 32'h0000_CAFE;
      issue(OP_MTLO, 32'h0000_1111, 32'd0);
      check("mtlo_lo", oLo, 32'h0000_1111);
      check("mtlo_hi", oHi, 32'h0000_CAFE);
      cur_lo = 32'h0000_1111;

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_BUSY,
             32'hFFFF_FFFE, 32'h0000_0001, -1);
      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'd2, MUL_BUSY,
             32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
      run_op("mult_negneg", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC, MUL_BUSY,
             32'd0, 32'd12, -1);
      run_op("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_BUSY,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
      // A strobe while busy must be ignored; result unaffected.
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, DIV_BUSY,
             32'd2, 32'd14, 4);
      run_op("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, DIV_BUSY,
             32'h0000_1234, 32'hFFFF_FFFF, -1);
      run_op("div_by0_neg", OP_DIV, 32'hFFFF_FFFB, 32'd0, DIV_BUSY,
             32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_BUSY,
             32'd0, 32'h8000_0000, -1);

      // Undefined op code is ignored.
      issue(3'd6, 32'h5555_5555, 32'd1);
      check("undef_busy", 32'(oBusy), 32'd0);
      check("undef_done", 32'(oDone), 32'd0);
      check("undef_hi", oHi, cur_hi);
      check("undef_lo", oLo, cur_lo);

      // Reset in cycle N+10 of a DIV aborts it; a strobe while busy is ignored.
      issue(OP_DIV, 32'd1000, 32'd3);
      repeat (2) cyc();
      iStart = 1'b1;
      iOp    = OP_MTHI;
      iA     = 32'h0000_0BAD;
      cyc();
      iStart = 1'b0;
      check("busy_strobe_hi", oHi, cur_hi);
      check("busy_strobe_busy", 32'(oBusy), 32'd1);
      repeat (6) cyc();
      iRst = 1'b1;
      cyc();
      iRst = 1'b0;
      check("abort_busy", 32'(oBusy), 32'd0);
      check("abort_done", 32'(oDone), 32'd0);
      check("abort_hi", oHi, 32'd0);
      check("abort_lo", oLo, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (oDone === 1'b1) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_hi_late", oHi, 32'd0);

      // Reset wins over a same-cycle strobe.
      iRst   = 1'b1;
      iStart = 1'b1;
      iOp    = OP_MTHI;
      iA     = 32'h0000_0055;
      cyc();
      iRst   = 1'b0;
      iStart = 1'b0;
      check("rst_prio_hi", oHi, 32'd0);

      issue(OP_MTLO, 32'h0000_0077, 32'd0);
      check("post_rst_mtlo", oLo, 32'h0000_0077);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have no parameters; op width and encodings come from `MDU_CWIDTH / `MDU_OP_* in defines.vh.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Port iClk is the clock; port iRst is the reset.
REQ-003 iClk  in  1  clock; all state updates on rising edge.
REQ-004 iRst  in  1  synchronous active-high reset.
REQ-005 iStart  in  1  request strobe; sampled with iOp/iA/iB.
REQ-006 iOp  in  `MDU_CWIDTH (3)  MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 iA  in  32  rs operand: multiplicand or dividend; source for MTHI/MTLO.
REQ-008 iB  in  32  rt operand: multiplier or divisor.
REQ-009 oBusy  out  1  iteration in progress; the controller stalls MFHI/MFLO and the next mult/div while it is high.
REQ-010 oDone  out  1  one-cycle pulse when HI/LO are updated by mult/div.
REQ-011 oHi, oLo  out  32 each  architectural HI/LO registers, driven directly from flops.

Function
REQ-012 FSM states SHALL be IDLE, MUL, DIV, FIX and DONE; the state after reset is IDLE.
REQ-013 In IDLE, iStart=1 with MULT/MULTU/DIV/DIVU latches the operands and the op, clears the step counter, and moves to MUL or DIV.
REQ-014 In IDLE, iStart=1 with MTHI/MTLO writes iA to HI or LO at that edge; no oBusy, no oDone.
REQ-015 An undefined iOp, or iStart while not in IDLE, SHALL be ignored with no state change.
REQ-016 Signed ops SHALL latch operand magnitudes plus result-sign flags; unsigned ops latch the operands unchanged.
REQ-017 MUL SHALL run radix-2 shift-add, one bit per cycle, for 32 cycles into a 64-bit accumulator.
REQ-018 DIV SHALL run a restoring shift-subtract, one quotient bit per cycle, for 32 cycles with a 33-bit partial remainder.
REQ-019 After step 31, the FSM SHALL enter FIX: apply sign correction, write HI/LO, then go to DONE.
REQ-020 DONE SHALL last one cycle with oDone=1 and oBusy=0, then return to IDLE.
REQ-021 Latency: iStart sampled at edge N; oBusy=1 in cycles N+1..N+33; HI/LO written at edge N+33; oDone=1 in the cycle after edge N+33.
REQ-022 The mult result SHALL be HI={prod[63:32]} and LO={prod[31:0]}; signed ops negate the 64-bit product when operand signs differ.
REQ-023 The div result SHALL be LO=quotient and HI=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-024 Divisor=0 SHALL still run the full latency and give HI=iA and LO=32'hFFFFFFFF, for both DIV and DIVU.
REQ-025 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-026 HI/LO SHALL NOT change between issue and FIX; the old values stay visible on oHi/oLo while busy.

Reset
REQ-027 iRst=1 SHALL force IDLE, HI=0, LO=0, oBusy=0, oDone=0 and clear the counter and accumulators.
REQ-028 Reset mid-operation SHALL abort with no HI/LO write. Reset has priority over iStart in the same cycle.

Configuration
REQ-029 Macro MDU_FAST_MUL_EN is the only compile-time option.
REQ-030 With MDU_FAST_MUL_EN defined, MULT/MULTU SHALL bypass MUL/FIX and compute a single-cycle 32x32 product. HI/LO are written at the issue edge N, oDone=1 in cycle N+1, and oBusy stays 0.
REQ-031 Without MDU_FAST_MUL_EN, multiply SHALL be iterative per REQ-017/021. Divide behaviour SHALL be identical in both builds.

Structure
REQ-032 `MDU_CWIDTH and the `MDU_OP_* encodings SHALL live in defines.vh beside the ALU op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
REQ-033 The one-bit-per-cycle shift-add / restore-subtract datapath SHALL be sub-module mdu_iter. mdu holds the FSM, sign handling and HI/LO.

Verification
REQ-034 MULTU with iA=iB=32'hFFFFFFFF SHALL give HI=32'hFFFFFFFE and LO=32'h00000001, with oDone in cycle N+34 (N+1 with MDU_FAST_MUL_EN).
REQ-035 MULT with iA=32'hFFFFFFFF and iB=2 SHALL give HI=32'hFFFFFFFF and LO=32'hFFFFFFFE.
REQ-036 DIV with iA=-7 and iB=2 SHALL give LO=32'hFFFFFFFD and HI=32'hFFFFFFFF. DIVU with iA=100 and iB=7 SHALL give LO=14 and HI=2.
REQ-037 DIVU with iA=32'h1234 and iB=0 SHALL give HI=32'h1234 and LO=32'hFFFFFFFF, with oBusy high for 33 cycles.
REQ-038 Reset in cycle N+10 of a DIV SHALL give oBusy=0, HI=LO=0 and no oDone; a second iStart while busy SHALL be ignored.
REQ-039 MTHI with iA=32'hCAFE SHALL give oHi=32'hCAFE at the next edge with oBusy=0 and oDone=0.
